// File: rtl/uart_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb_pkg
// Description : Shared types and helpers for the UART transmit arbiter.
//               - arb_state_t : arbiter FSM state encoding
//               - BYTE_W      : width of one transmitted byte
//               - idx_w()     : index width for an n-entry selection (min 1)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_WAIT    = 2'b01,
        ARB_HOLDOFF = 2'b10
    } arb_state_t;

    // Bits needed to hold an index 0..n-1; never less than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational round-robin picker. Selects the first asserted
//               request at or after ptr, wrapping modulo NUM_REQ.
// Ports       : req    (in)  request vector
//               ptr    (in)  highest-priority index this round
//               any    (out) at least one request asserted
//               winner (out) selected index (equals ptr when any is low)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [idx_w(NUM_REQ)-1:0]   ptr,
    output logic                        any,
    output logic [idx_w(NUM_REQ)-1:0]   winner
);

    localparam int IW = idx_w(NUM_REQ);

    int            cand;
    logic [IW-1:0] cand_idx;

    // Scan from the farthest offset down to offset 0 so that the valid
    // request nearest to ptr is the last one assigned and therefore wins.
    always_comb begin
        any      = |req;
        winner   = ptr;
        cand     = 0;
        cand_idx = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand     = (int'(ptr) + off) % NUM_REQ;
            cand_idx = IW'(cand);
            if (req[cand_idx]) begin
                winner = cand_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Round-robin arbiter/sequencer sharing one UART transmitter
//               among NUM_REQ byte producers. One byte per grant, launched
//               with a one-cycle tx_start; next grant only after tx_done and
//               an optional GAP_CYCLES holdoff.
// Ports       : tx_clk, tx_rst_n (async, active low)
//               req_valid/req_data (in)  producer bytes, byte i at [8i+7:8i]
//               req_ready          (out) one-hot acceptance pulse
//               tx_start/tx_data_out (out) launch strobe and byte
//               tx_done            (in)  end-of-frame pulse from transmitter
//               gnt_id             (out) last granted requester
//               arb_busy           (out) state is not ARB_IDLE
//               arb_err            (out) frame watchdog timeout pulse
// Options     : UART_TX_ARB_TIMEOUT_EN enables the frame watchdog
//               (TIMEOUT_CYCLES); otherwise arb_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                        tx_clk,
    input  logic                        tx_rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_start,
    output logic [BYTE_W-1:0]           tx_data_out,
    input  logic                        tx_done,
    output logic [idx_w(NUM_REQ)-1:0]   gnt_id,
    output logic                        arb_busy,
    output logic                        arb_err
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int GW = idx_w(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if (NUM_REQ < 2 || NUM_REQ > 16 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arb: parameter out of range");
    end

    arb_state_t     state;
    arb_state_t     state_next;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  ptr_next;
    logic [GW-1:0]  hold_cnt;
    logic [GW-1:0]  hold_next;
    logic           grant;
    logic           any_req;
    logic [IW-1:0]  winner;
    logic [NUM_REQ-1:0] ready_mask;
    logic           timeout;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .any    (any_req),
        .winner (winner)
    );

    assign ready_mask = NUM_REQ'(1) << winner;

    // ------------------------------------------------------------------
    // Frame watchdog
    // ------------------------------------------------------------------
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int WW = idx_w(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt;

    // wd_cnt holds the number of WAIT cycles already completed, so the
    // TIMEOUT_CYCLES-th WAIT cycle is the one seeing TIMEOUT_CYCLES-1.
    // A tx_done in that same cycle still wins.
    assign timeout = (state == ARB_WAIT) && !tx_done &&
                     (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            wd_cnt  <= '0;
            arb_err <= 1'b0;
        end else begin
            arb_err <= timeout;
            // Held at zero outside WAIT, which clears it on every entry.
            if (state != ARB_WAIT) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WW'(1);
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign arb_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        hold_next  = hold_cnt;
        grant      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    grant      = 1'b1;
                    state_next = ARB_WAIT;
                    ptr_next   = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + IW'(1);
                end
            end
            ARB_WAIT: begin
                if (tx_done) begin
                    if (GAP_CYCLES > 0) begin
                        state_next = ARB_HOLDOFF;
                        hold_next  = GAP_LOAD;
                    end else begin
                        state_next = ARB_IDLE;
                    end
                end else if (timeout) begin
                    state_next = ARB_IDLE;
                end
            end
            ARB_HOLDOFF: begin
                if (hold_cnt == '0) begin
                    state_next = ARB_IDLE;
                end else begin
                    hold_next = hold_cnt - GW'(1);
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Pointer, holdoff counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            ptr         <= '0;
            hold_cnt    <= '0;
            tx_start    <= 1'b0;
            req_ready   <= '0;
            tx_data_out <= '0;
            gnt_id      <= '0;
            arb_busy    <= 1'b0;
        end else begin
            ptr       <= ptr_next;
            hold_cnt  <= hold_next;
            tx_start  <= grant;
            req_ready <= grant ? ready_mask : '0;
            arb_busy  <= (state_next != ARB_IDLE);
            // Byte and id stay put between grants.
            if (grant) begin
                tx_data_out <= req_data[winner*BYTE_W +: BYTE_W];
                gnt_id      <= winner;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arb
// Description : Directed self-checking bench for uart_tx_arb. Instance dut
//               uses GAP_CYCLES=0, instance dut_g uses GAP_CYCLES=3; both use
//               TIMEOUT_CYCLES=16 and share clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

    logic        clk;
    logic        rst_n;

    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data_out;
    logic        tx_done;
    logic [1:0]  gnt_id;
    logic        arb_busy;
    logic        arb_err;

    logic [3:0]  req_valid_g;
    logic [31:0] req_data_g;
    logic [3:0]  req_ready_g;
    logic        tx_start_g;
    logic [7:0]  tx_data_out_g;
    logic        tx_done_g;
    logic [1:0]  gnt_id_g;
    logic        arb_busy_g;
    logic        arb_err_g;

    int checks;
    int errors;

    uart_tx_arb #(
        .NUM_REQ        (4),
        .GAP_CYCLES     (0),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .tx_clk      (clk),
        .tx_rst_n    (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data_out (tx_data_out),
        .tx_done     (tx_done),
        .gnt_id      (gnt_id),
        .arb_busy    (arb_busy),
        .arb_err     (arb_err)
    );

    uart_tx_arb #(
        .NUM_REQ        (4),
        .GAP_CYCLES     (3),
        .TIMEOUT_CYCLES (16)
    ) dut_g (
        .tx_clk      (clk),
        .tx_rst_n    (rst_n),
        .req_valid   (req_valid_g),
        .req_data    (req_data_g),
        .req_ready   (req_ready_g),
        .tx_start    (tx_start_g),
        .tx_data_out (tx_data_out_g),
        .tx_done     (tx_done_g),
        .gnt_id      (gnt_id_g),
        .arb_busy    (arb_busy_g),
        .arb_err     (arb_err_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        tick;
        checks++;
        if ({tx_start, req_ready, tx_data_out, gnt_id, arb_busy, arb_err} !== 17'h0) begin
            errors++;
            $display("FAIL reset_values: got start=%b ready=%b data=%h gnt=%0d busy=%b err=%b, want all 0",
                     tx_start, req_ready, tx_data_out, gnt_id, arb_busy, arb_err);
        end
        checks++;
        if ({tx_start_g, arb_busy_g} !== 2'b00) begin
            errors++;
            $display("FAIL reset_values_gap: got start=%b busy=%b, want 0 0", tx_start_g, arb_busy_g);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin;
        logic [7:0] bytes [4];
        int exp_id;
        bytes = '{8'h10, 8'h21, 8'h32, 8'h43};
        req_data  = {bytes[3], bytes[2], bytes[1], bytes[0]};
        req_valid = 4'hF;
        tick;
        for (int k = 0; k < 5; k++) begin
            exp_id = k % 4;
            checks++;
            if (tx_start !== 1'b1 || gnt_id !== 2'(exp_id)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got start=%b gnt=%0d, want start=1 gnt=%0d",
                         k, tx_start, gnt_id, exp_id);
            end
            checks++;
            if (tx_data_out !== bytes[exp_id] || req_ready !== (4'b0001 << exp_id)) begin
                errors++;
                $display("FAIL rr_data[%0d]: got data=%h ready=%b, want data=%h ready=%b",
                         k, tx_data_out, req_ready, bytes[exp_id], 4'b0001 << exp_id);
            end
            repeat (9) tick;
            tx_done = 1'b1;
            tick;
            tx_done = 1'b0;
            checks++;
            if (tx_start !== 1'b0 || arb_busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_turnaround[%0d]: got start=%b busy=%b, want 0 0", k, tx_start, arb_busy);
            end
            if (k < 4) begin
                tick;
            end else begin
                req_valid = 4'h0;
            end
        end
    endtask

    task automatic test_single;
        logic bad;
        req_data  = 32'h0000_3C00;
        req_valid = 4'b0010;
        tick;
        checks++;
        if (tx_start !== 1'b1 || req_ready !== 4'b0010 || gnt_id !== 2'd1 ||
            tx_data_out !== 8'h3C || arb_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got start=%b ready=%b gnt=%0d data=%h busy=%b, want 1 0010 1 3c 1",
                     tx_start, req_ready, gnt_id, tx_data_out, arb_busy);
        end
        req_valid = 4'b0000;
        bad = 1'b0;
        repeat (3) begin
            tick;
            if (tx_start !== 1'b0 || arb_busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL single_wait: got bad=%b, want start=0 busy=1 while waiting", bad);
        end
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        checks++;
        if (arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got busy=%b, want 0", arb_busy);
        end
        bad = 1'b0;
        repeat (4) begin
            tick;
            if (tx_start !== 1'b0 || arb_busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL single_no_regrant: got bad=%b, want idle outputs", bad);
        end
    endtask

    task automatic test_spurious_done;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        checks++;
        if (tx_start !== 1'b0 || arb_busy !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL spurious_done: got start=%b busy=%b ready=%b, want 0 0 0000",
                     tx_start, arb_busy, req_ready);
        end
        tick;
        checks++;
        if (tx_start !== 1'b0 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_done_after: got start=%b busy=%b, want 0 0", tx_start, arb_busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        // ptr is 2 here, so the scan 2,3,0 lands on requester 0.
        req_data  = 32'h0000_005E;
        req_valid = 4'b0001;
        tick;
        checks++;
        if (tx_start !== 1'b1 || gnt_id !== 2'd0 || tx_data_out !== 8'h5E) begin
            errors++;
            $display("FAIL mid_pre_grant: got start=%b gnt=%0d data=%h, want 1 0 5e",
                     tx_start, gnt_id, tx_data_out);
        end
        req_valid = 4'b0000;
        tick;
        checks++;
        if (arb_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_wait: got busy=%b, want 1", arb_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_start, req_ready, tx_data_out, gnt_id, arb_busy, arb_err} !== 17'h0) begin
            errors++;
            $display("FAIL mid_async_reset: got start=%b ready=%b data=%h gnt=%0d busy=%b err=%b, want all 0",
                     tx_start, req_ready, tx_data_out, gnt_id, arb_busy, arb_err);
        end
        tick;
        tick;
        rst_n     = 1'b1;
        req_data  = 32'h00A5_0000;
        req_valid = 4'b0100;
        tick;
        checks++;
        if (tx_start !== 1'b1 || req_ready !== 4'b0100 || tx_data_out !== 8'hA5 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL mid_post_grant: got start=%b ready=%b data=%h gnt=%0d, want 1 0100 a5 2",
                     tx_start, req_ready, tx_data_out, gnt_id);
        end
        req_valid = 4'b0000;
        tick;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
    endtask

    task automatic test_gap;
        logic [3:0] busy_trace;
        req_data_g  = 32'h0000_0077;
        req_valid_g = 4'b0001;
        tick;
        checks++;
        if (tx_start_g !== 1'b1 || gnt_id_g !== 2'd0) begin
            errors++;
            $display("FAIL gap_first_grant: got start=%b gnt=%0d, want 1 0", tx_start_g, gnt_id_g);
        end
        tick;
        tick;
        tx_done_g = 1'b1;
        tick;
        tx_done_g = 1'b0;
        busy_trace[0] = arb_busy_g;
        tick;
        busy_trace[1] = arb_busy_g;
        tick;
        busy_trace[2] = arb_busy_g;
        tick;
        busy_trace[3] = arb_busy_g;
        checks++;
        if (busy_trace !== 4'b0111 || tx_start_g !== 1'b0) begin
            errors++;
            $display("FAIL gap_holdoff: got busy trace=%b start=%b, want 0111 0", busy_trace, tx_start_g);
        end
        tick;
        checks++;
        if (tx_start_g !== 1'b1 || gnt_id_g !== 2'd0 || tx_data_out_g !== 8'h77) begin
            errors++;
            $display("FAIL gap_next_start: got start=%b gnt=%0d data=%h, want 1 0 77",
                     tx_start_g, gnt_id_g, tx_data_out_g);
        end
        req_valid_g = 4'b0000;
        tick;
        tx_done_g = 1'b1;
        tick;
        tx_done_g = 1'b0;
    endtask

    task automatic test_timeout;
        // ptr is 3 after the post-reset grant of requester 2.
        req_data  = 32'h9900_0000;
        req_valid = 4'b1000;
        tick;
        checks++;
        if (tx_start !== 1'b1 || gnt_id !== 2'd3) begin
            errors++;
            $display("FAIL to_grant: got start=%b gnt=%0d, want 1 3", tx_start, gnt_id);
        end
        req_valid = 4'b0000;
`ifdef UART_TX_ARB_TIMEOUT_EN
        begin
            int first_err;
            int err_cycles;
            logic busy_at_err;
            first_err   = 0;
            err_cycles  = 0;
            busy_at_err = 1'b1;
            // k=1 is the first WAIT cycle; the pulse belongs in cycle 17.
            for (int k = 1; k <= 40; k++) begin
                if (arb_err === 1'b1) begin
                    err_cycles++;
                    if (first_err == 0) begin
                        first_err   = k;
                        busy_at_err = arb_busy;
                    end
                end
                tick;
            end
            checks++;
            if (first_err != 17 || err_cycles != 1) begin
                errors++;
                $display("FAIL to_pulse: got first cycle=%0d count=%0d, want 17 1", first_err, err_cycles);
            end
            checks++;
            if (busy_at_err !== 1'b0) begin
                errors++;
                $display("FAIL to_idle: got busy=%b at error pulse, want 0", busy_at_err);
            end
        end
`else
        begin
            logic err_seen;
            logic busy_dropped;
            err_seen     = 1'b0;
            busy_dropped = 1'b0;
            repeat (40) begin
                tick;
                if (arb_err !== 1'b0) err_seen = 1'b1;
                if (arb_busy !== 1'b1) busy_dropped = 1'b1;
            end
            checks++;
            if (err_seen !== 1'b0 || busy_dropped !== 1'b0) begin
                errors++;
                $display("FAIL no_timeout: got err_seen=%b busy_dropped=%b, want 0 0", err_seen, busy_dropped);
            end
            tx_done = 1'b1;
            tick;
            tx_done = 1'b0;
            checks++;
            if (arb_busy !== 1'b0 || arb_err !== 1'b0) begin
                errors++;
                $display("FAIL no_timeout_done: got busy=%b err=%b, want 0 0", arb_busy, arb_err);
            end
        end
`endif
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        req_valid   = 4'h0;
        req_data    = 32'h0;
        tx_done     = 1'b0;
        req_valid_g = 4'h0;
        req_data_g  = 32'h0;
        tx_done_g   = 1'b0;

        test_reset;
        test_round_robin;
        test_single;
        test_spurious_done;
        test_reset_mid_frame;
        test_gap;
        test_timeout;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
